// File: rtl/func_pipe_param.sv
// func_pipe_param: sequential evaluator of y = a*b + a^3 for W-bit unsigned operands.
// One shared shift-add multiplier is reused for a*a, (a*a)*a and a*b, then a final
// add produces the 3W-bit result. The start/busy handshake accepts one operation at a time,
// and done_o pulses for one cycle when y_o updates.
// Optional feature: define FUNC_PIPE_EARLY_EXIT_EN to end each multiply as soon as the
// remaining multiplier bits are all zero (data-dependent latency, identical results).
module func_pipe_param #(
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,    // asynchronous, active low
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [3*W-1:0] y_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CntLast = CW'(W - 1);

  typedef enum logic [2:0] {StIdle, StSq, StCube, StProd, StSum} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [3*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [3*W-1:0] acc_q, acc_d;
  logic [3*W-1:0] p2_q, p2_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3*W-1:0] y_q, y_d;
  logic           done_q, done_d;

  logic [3*W-1:0] acc_step;
  logic           last_step;

  // One multiplier step: add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef FUNC_PIPE_EARLY_EXIT_EN
    // Stop once no set bits remain above the one retired this cycle.
    last_step = (mplier_q[W-1:1] == '0) || (cnt_q == CntLast);
`else
    last_step = (cnt_q == CntLast);
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p2_d     = p2_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          mcand_d  = {{(2*W){1'b0}}, a_i};
          mplier_d = a_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StSq;
        end
      end
      StSq, StCube, StProd: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          cnt_d = '0;
          acc_d = '0;
          if (state_q == StSq) begin
            // p1 = a*a becomes the multiplicand for the cube.
            mcand_d  = acc_step;
            mplier_d = a_q;
            state_d  = StCube;
          end else if (state_q == StCube) begin
            p2_d     = acc_step;
            mcand_d  = {{(2*W){1'b0}}, a_q};
            mplier_d = b_q;
            state_d  = StProd;
          end else begin
            // p3 = a*b is parked in the accumulator for the final add.
            acc_d   = acc_step;
            state_d = StSum;
          end
        end
      end
      StSum: begin
        y_d     = p2_q + acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p2_q     <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p2_q     <= p2_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      done_q   <= done_d;
    end
  end

  // Outputs: busy follows the state; done is the registered completion pulse.
  always_comb begin
    y_o    = y_q;
    busy_o = (state_q != StIdle);
    done_o = done_q;
  end

endmodule

// File: tb/tb_func_pipe_param.sv
// Directed testbench for func_pipe_param (W=8 main instance, W=4 secondary instance).
module tb_func_pipe_param;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [23:0] y;
  logic        busy;
  logic        done;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic [11:0] y4;
  logic        busy4;
  logic        done4;

  int total_cnt = 0;
  int bad_cnt   = 0;

  func_pipe_param #(.W(8)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .y_o    (y),
    .busy_o (busy),
    .done_o (done)
  );

  func_pipe_param #(.W(4)) u_dut4 (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .start_i(start4),
    .a_i    (a4),
    .b_i    (b4),
    .y_o    (y4),
    .busy_o (busy4),
    .done_o (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bitlen(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Expected number of busy cycles for one operation (W=8).
  function automatic int exp_lat(input logic [7:0] av, input logic [7:0] bv);
`ifdef FUNC_PIPE_EARLY_EXIT_EN
    int la = (bitlen(av) < 1) ? 1 : bitlen(av);
    int lb = (bitlen(bv) < 1) ? 1 : bitlen(bv);
    return 2 * la + lb + 1;
`else
    return 25 + 0 * (bitlen(av) + bitlen(bv));
`endif
  endfunction

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // Waits (bounded) for done; counts busy cycles and elapsed cycles.
  task automatic wait_done(output int busy_n, output int cyc);
    busy_n = 0;
    cyc    = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check_val("done_timeout", 64'(cyc), 64'(0));
    check_val("busy_and_done", 64'(busy & done), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [23:0] exp_y);
    int bn;
    int cy;
    issue(av, bv);
    wait_done(bn, cy);
    check_val({tag, "_y"}, 64'(y), 64'(exp_y));
    check_val({tag, "_busy"}, 64'(bn), 64'(exp_lat(av, bv)));
    @(negedge clk);
    check_val({tag, "_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int bn;
    int cy;
    int extra;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    repeat (2) @(negedge clk);
    check_val("rst_y", 64'(y), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("zero", 8'd0, 8'd0, 24'd0);
    run_op("full", 8'd255, 8'd255, 24'd16646400);
    run_op("a15b240", 8'd15, 8'd240, 24'd6975);
    run_op("a240b15", 8'd240, 8'd15, 24'd13827600);
    run_op("a1b0", 8'd1, 8'd0, 24'd1);

    // Start pulsed mid-operation is ignored and not queued.
    issue(8'd170, 8'd85);
    repeat (5) @(negedge clk);
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bn, cy);
    check_val("midstart_y", 64'(y), 64'(4927450));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_val("midstart_no_queue", 64'(extra), 64'(0));
    check_val("midstart_idle", 64'(busy), 64'(0));

    // Back-to-back: second start issued during the done cycle.
    issue(8'd3, 8'd4);
    wait_done(bn, cy);
    check_val("b2b_first_y", 64'(y), 64'(39));
    issue(8'd100, 8'd125);
    wait_done(bn, cy);
    check_val("b2b_second_y", 64'(y), 64'(1012500));
    check_val("b2b_gap", 64'(cy + 1), 64'(exp_lat(8'd100, 8'd125) + 1));
    @(negedge clk);

    // Asynchronous reset mid-operation clears outputs with no clock edge.
    issue(8'd255, 8'd255);
    repeat (9) @(negedge clk);
    check_val("pre_rst_busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_busy", 64'(busy), 64'(0));
    check_val("async_rst_done", 64'(done), 64'(0));
    check_val("async_rst_y", 64'(y), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 8'd7, 8'd9, 24'd406);

    // W=4 instance: a=15, b=15 -> 3600 after 13 busy cycles.
    start4 = 1'b1;
    a4     = 4'd15;
    b4     = 4'd15;
    @(negedge clk);
    start4 = 1'b0;
    a4     = 4'd0;
    b4     = 4'd0;
    bn     = 0;
    cy     = 0;
    while (!done4 && cy < 100) begin
      if (busy4) bn++;
      @(negedge clk);
      cy++;
    end
    check_val("w4_y", 64'(y4), 64'(3600));
    check_val("w4_busy", 64'(bn), 64'(13));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/func_pipe_param.md
# func_pipe_param

Parametrised sequential evaluator of y = a·b + a³ for W-bit unsigned operands. It is the width-generic successor of the fixed 8-bit function unit and keeps the same start/busy handshake. It adds a done pulse and uses a single shared shift-add multiplier, giving a deterministic latency that is optionally data-dependent. It sits behind a controller that issues one operation at a time and samples the result on `done_o`.

## Interface
- `W`, default 8: operand width, W ≥ 2. The result is 3W bits wide.
- `clk_i`  in  1  sole clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request. It is sampled only in IDLE; the cycle it is accepted, `a_i`/`b_i` are latched.
- `a_i`  in  W  operand a, unsigned.
- `b_i`  in  W  operand b, unsigned.
- `y_o`  out  3W  last completed result. It holds its value until the next completion.
- `busy_o`  out  1  high while an operation is in flight.
- `done_o`  out  1  one-cycle pulse when `y_o` updates.

## Operation
- FSM states: IDLE → SQ → CUBE → PROD → SUM → IDLE.
  - IDLE: on `start_i`=1, latch a and b, clear the accumulator, go to SQ.
  - SQ: compute p1 = a·a (multiplicand a, multiplier a).
  - CUBE: compute p2 = p1·a (2W-bit multiplicand, multiplier a).
  - PROD: compute p3 = a·b (multiplicand a, multiplier b).
  - SUM: set y_o = p2 + p3, pulse `done_o`, return to IDLE.
- Multiplier: one shared shift-add unit retiring one multiplier bit per cycle, LSB first. The accumulator is 3W bits; the multiplicand register is 3W bits and shifts left each step.
- Width rule: the maximum result is (2^W−1)²·2^W < 2^(3W), so there is no overflow and no truncation. All arithmetic is unsigned and zero-extended.
- `start_i` while `busy_o`=1 is ignored. It is not queued, and latched operands are unaffected.
- Inputs may change freely after the accept cycle.
- Reset values, asserted asynchronously at any time including mid-operation:
  - state = IDLE
  - `busy_o`=0, `done_o`=0, `y_o`=0
  - internal registers = 0
  - No partial result is ever exposed.

## Timing
- Accept edge k: `start_i`=1 in IDLE. `busy_o` goes high after edge k.
- Default (macro absent):
  - SQ, CUBE and PROD each take exactly W cycles; SUM takes 1.
  - `busy_o` is high for exactly 3W+1 cycles.
  - After edge k+3W+1: `y_o` is valid, `done_o`=1 for that single cycle, `busy_o`=0.
- Back-to-back: `start_i`=1 during the `done_o` cycle is accepted, since the state is IDLE. This gives a throughput of one result per 3W+2 cycles.
- `done_o` and `busy_o` are never high together.

## Configuration
- Macro: `FUNC_PIPE_EARLY_EXIT_EN`.
- Defined:
  - Each multiply state exits as soon as the remaining unshifted multiplier bits are all zero, after at least 1 cycle.
  - Latency becomes data-dependent: minimum 4 cycles (SQ 1, CUBE 1, PROD 1, SUM 1), maximum 3W+1.
  - Results are identical to the default build.
- Undefined: fixed latency of 3W+1 busy cycles, as described in Timing.

## Test plan (W=8 unless noted)
- a=0, b=0 → y_o=0. Default build: `busy_o` high 25 cycles, single `done_o` pulse. Early-exit build: 4 busy cycles.
- a=255, b=255 → y_o=16646400 (full-range, no overflow). a=15, b=240 → 6975. a=240, b=15 → 13827600.
- `start_i` pulsed mid-operation with a=1, b=1 while computing a=170, b=85 → y_o=4927450. The second request is ignored; exactly one `done_o` pulse.
- Back-to-back: second start with a=100, b=125 issued in the `done_o` cycle of the first → accepted → y_o=1012500, 26 cycles after the first done.
- `rst_i` driven low at busy cycle 10 → `busy_o`, `done_o` and `y_o` are 0 immediately with no clock required. A new start after release gives the correct result.
- Early-exit build, a=1, b=0 → y_o=1 after 4 busy cycles. W=4 default build, a=15, b=15 → y_o=3600 after 13 busy cycles.
